ps2_mouse_command_tx: RTL and testbench

//  Host-to-device PS/2 transmitter: sends one command byte to the mouse (e.g. 0xF4 enable

---
 rtl/ps2_mouse_command_tx_pkg.sv | 41 ++++
 rtl/ps2_line_sync.sv | 36 +++
 rtl/ps2_mouse_command_tx.sv | 174 +++++++++++++++++
 tb/tb_ps2_mouse_command_tx.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_mouse_command_tx_pkg.sv
// Shared definitions for the PS/2 mouse host-to-device command path: FSM states,
// well-known mouse command bytes, default bus timing and frame/timer helpers.
package ps2_mouse_command_tx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_INHIBIT,
        ST_RTS,
        ST_SHIFT,
        ST_WAIT_ACK,
        ST_WAIT_IDLE,
        ST_DONE,
        ST_ERR
    } tx_state_t;

    localparam logic [7:0] CMD_RESET    = 8'hFF;
    localparam logic [7:0] CMD_ENABLE   = 8'hF4;
    localparam logic [7:0] CMD_SET_RATE = 8'hF3;

    // Defaults assume a 50 MHz system clock.
    localparam int DEF_INHIBIT_CYCLES = 5000;
    localparam int DEF_START_TIMEOUT  = 750000;
    localparam int DEF_XFER_TIMEOUT   = 100000;
    localparam int DEF_IDLE_TIMEOUT   = 100000;

    // Wire order, LSB first: data[7:0], odd parity, stop.
    function automatic logic [9:0] build_frame(input logic [7:0] cmd);
        return {1'b1, ~^cmd, cmd};
    endfunction

    // The single timeout counter must hold whichever reload value is largest.
    function automatic int timer_width(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// Brings the raw PS/2 clock and data levels into the system clock domain and
// emits a one-cycle strobe on each falling edge of the synchronised clock line.
module ps2_line_sync (
    input  logic CLOCK_50,
    input  logic resetn,
    input  logic clk_in,
    input  logic dat_in,
    output logic clk_sync,
    output logic dat_sync,
    output logic clk_neg
);

    logic clk_meta;
    logic dat_meta;
    logic clk_prev;

    // Preset to 1 so an idle (pulled-up) bus never looks like an edge after reset.
    always_ff @(posedge CLOCK_50) begin
        if (!resetn) begin
            clk_meta <= 1'b1;
            clk_sync <= 1'b1;
            dat_meta <= 1'b1;
            dat_sync <= 1'b1;
            clk_prev <= 1'b1;
            clk_neg  <= 1'b0;
        end else begin
            clk_meta <= clk_in;
            clk_sync <= clk_meta;
            dat_meta <= dat_in;
            dat_sync <= dat_meta;
            clk_prev <= clk_sync;
            clk_neg  <= clk_prev & ~clk_sync;
        end
    end

endmodule

// File: rtl/ps2_mouse_command_tx.sv
// Host-to-device PS/2 transmitter: inhibits the bus, requests to send, then shifts
// one command byte out on device clock edges and waits for the device ACK.
module ps2_mouse_command_tx
    import ps2_mouse_command_tx_pkg::*;
#(
    parameter int INHIBIT_CYCLES = DEF_INHIBIT_CYCLES,
    parameter int START_TIMEOUT  = DEF_START_TIMEOUT,
    parameter int XFER_TIMEOUT   = DEF_XFER_TIMEOUT,
    parameter int IDLE_TIMEOUT   = DEF_IDLE_TIMEOUT
) (
    input  logic       CLOCK_50,
    input  logic       resetn,
    input  logic [7:0] the_command,
    input  logic       send_command,
    input  logic       ps2_clk_in,
    input  logic       ps2_dat_in,
    output logic       ps2_clk_drive_low,
    output logic       ps2_dat_drive_low,
    output logic       busy,
    output logic       command_was_sent,
    output logic       error_timed_out
);

    localparam int TIMER_W = timer_width(INHIBIT_CYCLES, START_TIMEOUT, XFER_TIMEOUT, IDLE_TIMEOUT);
    localparam logic [TIMER_W-1:0] LD_INHIBIT = TIMER_W'(INHIBIT_CYCLES - 1);
    localparam logic [TIMER_W-1:0] LD_START   = TIMER_W'(START_TIMEOUT - 1);
    localparam logic [TIMER_W-1:0] LD_XFER    = TIMER_W'(XFER_TIMEOUT - 1);
    localparam logic [TIMER_W-1:0] LD_IDLE    = TIMER_W'(IDLE_TIMEOUT - 1);

    logic clk_sync;
    logic dat_sync;
    logic clk_neg;

    tx_state_t          state;
    logic [9:0]         frame;
    logic [3:0]         bit_cnt;
    logic [TIMER_W-1:0] timer;

    ps2_line_sync u_line_sync (
        .CLOCK_50 (CLOCK_50),
        .resetn   (resetn),
        .clk_in   (ps2_clk_in),
        .dat_in   (ps2_dat_in),
        .clk_sync (clk_sync),
        .dat_sync (dat_sync),
        .clk_neg  (clk_neg)
    );

    always_ff @(posedge CLOCK_50) begin
        if (!resetn) begin
            state             <= ST_IDLE;
            frame             <= '0;
            bit_cnt           <= '0;
            timer             <= '0;
            ps2_clk_drive_low <= 1'b0;
            ps2_dat_drive_low <= 1'b0;
            busy              <= 1'b0;
            command_was_sent  <= 1'b0;
            error_timed_out   <= 1'b0;
        end else begin
            command_was_sent <= 1'b0;
            error_timed_out  <= 1'b0;

            case (state)
                ST_IDLE: begin
                    ps2_clk_drive_low <= 1'b0;
                    ps2_dat_drive_low <= 1'b0;
                    if (send_command && !busy) begin
                        frame             <= build_frame(the_command);
                        busy              <= 1'b1;
                        ps2_clk_drive_low <= 1'b1;
                        ps2_dat_drive_low <= (INHIBIT_CYCLES == 1);
                        timer             <= LD_INHIBIT;
                        state             <= ST_INHIBIT;
                    end
                end

                // Any clock edges seen here are our own inhibit, so clk_neg is ignored.
                ST_INHIBIT: begin
                    if (timer == '0) begin
                        ps2_clk_drive_low <= 1'b0;
                        ps2_dat_drive_low <= 1'b1;
                        timer             <= LD_START;
                        state             <= ST_RTS;
                    end else begin
                        if (timer == TIMER_W'(1)) ps2_dat_drive_low <= 1'b1;
                        timer <= timer - 1'b1;
                    end
                end

                ST_RTS: begin
                    if (clk_neg) begin
                        ps2_dat_drive_low <= ~frame[0];
                        bit_cnt           <= 4'd1;
                        timer             <= LD_XFER;
                        state             <= ST_SHIFT;
                    end else if (timer == '0) begin
                        ps2_clk_drive_low <= 1'b0;
                        ps2_dat_drive_low <= 1'b0;
                        busy              <= 1'b0;
                        error_timed_out   <= 1'b1;
                        state             <= ST_ERR;
                    end else begin
                        timer <= timer - 1'b1;
                    end
                end

                // The transfer timeout keeps running from here through the ACK.
                ST_SHIFT: begin
                    if (timer == '0) begin
                        ps2_clk_drive_low <= 1'b0;
                        ps2_dat_drive_low <= 1'b0;
                        busy              <= 1'b0;
                        error_timed_out   <= 1'b1;
                        state             <= ST_ERR;
                    end else begin
                        timer <= timer - 1'b1;
                        if (clk_neg) begin
                            ps2_dat_drive_low <= ~frame[bit_cnt];
                            if (bit_cnt == 4'd9) state <= ST_WAIT_ACK;
                            else bit_cnt <= bit_cnt + 4'd1;
                        end
                    end
                end

                ST_WAIT_ACK: begin
                    if (clk_neg && !dat_sync) begin
                        timer <= LD_IDLE;
                        state <= ST_WAIT_IDLE;
                    end else if (clk_neg || timer == '0) begin
                        ps2_clk_drive_low <= 1'b0;
                        ps2_dat_drive_low <= 1'b0;
                        busy              <= 1'b0;
                        error_timed_out   <= 1'b1;
                        state             <= ST_ERR;
                    end else begin
                        timer <= timer - 1'b1;
                    end
                end

                ST_WAIT_IDLE: begin
                    if (clk_sync && dat_sync) begin
                        busy             <= 1'b0;
                        command_was_sent <= 1'b1;
                        state            <= ST_DONE;
                    end else if (timer == '0) begin
                        ps2_clk_drive_low <= 1'b0;
                        ps2_dat_drive_low <= 1'b0;
                        busy              <= 1'b0;
                        error_timed_out   <= 1'b1;
                        state             <= ST_ERR;
                    end else begin
                        timer <= timer - 1'b1;
                    end
                end

                // Pulse cycle: requests arriving now are dropped, not queued.
                ST_DONE, ST_ERR: begin
                    ps2_clk_drive_low <= 1'b0;
                    ps2_dat_drive_low <= 1'b0;
                    state             <= ST_IDLE;
                end

                default: begin
                    ps2_clk_drive_low <= 1'b0;
                    ps2_dat_drive_low <= 1'b0;
                    busy              <= 1'b0;
                    state             <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ps2_mouse_command_tx.sv
// Bench for ps2_mouse_command_tx with an open-drain PS/2 device model on both lines.
module tb_ps2_mouse_command_tx;
    import ps2_mouse_command_tx_pkg::*;

    localparam int INH      = 1000;
    localparam int START_TO = 3000;
    localparam int XFER_TO  = 6000;
    localparam int IDLE_TO  = 3000;
    localparam int HALF     = 100;

    localparam logic [1:0] OUT_SENT = 2'b01;
    localparam logic [1:0] OUT_ERR  = 2'b10;

    typedef struct {
        logic [7:0] cmd;
        bit         ack_ok;
        bit         exp_parity;
        logic [1:0] exp_out;
    } vec_t;

    logic       CLOCK_50 = 1'b0;
    logic       resetn = 1'b0;
    logic [7:0] the_command = 8'h00;
    logic       send_command = 1'b0;
    logic       dev_clk = 1'b1;
    logic       dev_dat = 1'b1;
    logic       ps2_clk_line;
    logic       ps2_dat_line;
    logic       ps2_clk_drive_low;
    logic       ps2_dat_drive_low;
    logic       busy;
    logic       command_was_sent;
    logic       error_timed_out;

    int          checks = 0;
    int          errors = 0;
    int unsigned cyc = 0;
    int          both_low_cnt = 0;
    logic [1:0]  exp_q[$];
    logic [1:0]  mon_exp;
    vec_t        vecs[6];

    assign ps2_clk_line = ~ps2_clk_drive_low & dev_clk;
    assign ps2_dat_line = ~ps2_dat_drive_low & dev_dat;

    ps2_mouse_command_tx #(
        .INHIBIT_CYCLES (INH),
        .START_TIMEOUT  (START_TO),
        .XFER_TIMEOUT   (XFER_TO),
        .IDLE_TIMEOUT   (IDLE_TO)
    ) dut (
        .CLOCK_50          (CLOCK_50),
        .resetn            (resetn),
        .the_command       (the_command),
        .send_command      (send_command),
        .ps2_clk_in        (ps2_clk_line),
        .ps2_dat_in        (ps2_dat_line),
        .ps2_clk_drive_low (ps2_clk_drive_low),
        .ps2_dat_drive_low (ps2_dat_drive_low),
        .busy              (busy),
        .command_was_sent  (command_was_sent),
        .error_timed_out   (error_timed_out)
    );

    // Clock and cycle counter
    always #10 CLOCK_50 = ~CLOCK_50;
    always @(posedge CLOCK_50) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard: every done/error pulse pops one expected outcome.
    always @(negedge CLOCK_50) begin
        if (ps2_clk_drive_low && ps2_dat_drive_low) both_low_cnt++;
        if (resetn && (command_was_sent || error_timed_out)) begin
            if (exp_q.size() == 0) begin
                check("unexpected_pulse", {30'd0, error_timed_out, command_was_sent}, 32'd0);
            end else begin
                mon_exp = exp_q.pop_front();
                check("outcome", {30'd0, error_timed_out, command_was_sent}, {30'd0, mon_exp});
            end
            check("busy_at_pulse", busy, 0);
            check("lines_released_at_pulse", {ps2_clk_drive_low, ps2_dat_drive_low}, 0);
        end
    end

    // Driver tasks
    task automatic send(input logic [7:0] c, input bit push, input logic [1:0] out);
        @(negedge CLOCK_50);
        the_command  = c;
        send_command = 1'b1;
        if (push) exp_q.push_back(out);
        @(negedge CLOCK_50);
        send_command = 1'b0;
        the_command  = 8'($urandom_range(0, 255));
    endtask

    task automatic measure_inhibit(output int n);
        n = 0;
        while (ps2_clk_drive_low && n < 2 * INH) begin
            n++;
            @(negedge CLOCK_50);
        end
    endtask

    task automatic wait_rts(output bit ok);
        int n = 0;
        while (!(ps2_clk_line && !ps2_dat_line) && n < 2 * INH) begin
            n++;
            @(negedge CLOCK_50);
        end
        ok = ps2_clk_line && !ps2_dat_line;
    endtask

    task automatic dev_pulse(output logic sampled);
        dev_clk = 1'b0;
        repeat (HALF) @(negedge CLOCK_50);
        dev_clk = 1'b1;
        sampled = ps2_dat_line;
        repeat (HALF) @(negedge CLOCK_50);
    endtask

    task automatic dev_transfer(input bit ack_ok, output logic [9:0] frame, output bit ok);
        logic b;
        frame = '0;
        wait_rts(ok);
        if (!ok) return;
        repeat (HALF) @(negedge CLOCK_50);
        for (int i = 0; i < 10; i++) begin
            dev_pulse(b);
            frame[i] = b;
        end
        dev_dat = ack_ok ? 1'b0 : 1'b1;
        repeat (HALF / 2) @(negedge CLOCK_50);
        dev_clk = 1'b0;
        repeat (HALF) @(negedge CLOCK_50);
        dev_clk = 1'b1;
        repeat (HALF / 2) @(negedge CLOCK_50);
        dev_dat = 1'b1;
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < 2 * IDLE_TO) begin
            n++;
            @(negedge CLOCK_50);
        end
        check(name, exp_q.size(), 0);
        repeat (20) @(negedge CLOCK_50);
    endtask

    task automatic run_vec(input vec_t v);
        int n;
        bit ok;
        logic [9:0] frame;
        both_low_cnt = 0;
        send(v.cmd, 1'b1, v.exp_out);
        check("busy_after_accept", busy, 1);
        measure_inhibit(n);
        check("inhibit_len", n, INH);
        check("start_bit_overlap_cycles", both_low_cnt, 1);
        dev_transfer(v.ack_ok, frame, ok);
        check("rts_seen", ok, 1);
        check("data_bits", frame[7:0], v.cmd);
        check("parity_bit", frame[8], v.exp_parity);
        check("stop_bit", frame[9], 1);
        wait_drain("outcome_drained");
    endtask

    initial begin
        repeat (200000) @(posedge CLOCK_50);
        $display("FAIL watchdog: simulation exceeded cycle budget");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        bit ok;
        logic b;
        logic [7:0] rnd;
        logic [9:0] frame;
        int unsigned t0;

        rnd = 8'($urandom_range(0, 255));
        vecs[0] = '{cmd: CMD_ENABLE,   ack_ok: 1'b1, exp_parity: 1'b0, exp_out: OUT_SENT};
        vecs[1] = '{cmd: CMD_RESET,    ack_ok: 1'b1, exp_parity: 1'b1, exp_out: OUT_SENT};
        vecs[2] = '{cmd: CMD_SET_RATE, ack_ok: 1'b1, exp_parity: 1'b1, exp_out: OUT_SENT};
        vecs[3] = '{cmd: 8'h01,        ack_ok: 1'b1, exp_parity: 1'b0, exp_out: OUT_SENT};
        vecs[4] = '{cmd: 8'hAA,        ack_ok: 1'b0, exp_parity: 1'b1, exp_out: OUT_ERR};
        vecs[5] = '{cmd: rnd,          ack_ok: 1'b1, exp_parity: ~^rnd, exp_out: OUT_SENT};

        // Reset state
        resetn = 1'b0;
        repeat (5) @(negedge CLOCK_50);
        check("reset_clk_drive", ps2_clk_drive_low, 0);
        check("reset_dat_drive", ps2_dat_drive_low, 0);
        check("reset_busy", busy, 0);
        check("reset_sent", command_was_sent, 0);
        check("reset_err", error_timed_out, 0);
        resetn = 1'b1;
        repeat (10) @(negedge CLOCK_50);

        // Table-driven transfers, including a NACK from the device
        for (int i = 0; i < 6; i++) run_vec(vecs[i]);

        // Second request while busy is dropped; request in the DONE cycle is dropped too
        send(CMD_ENABLE, 1'b1, OUT_SENT);
        repeat (20) @(negedge CLOCK_50);
        send(8'h00, 1'b0, OUT_SENT);
        check("busy_held_during_inhibit", busy, 1);
        dev_transfer(1'b1, frame, ok);
        check("busy_case_rts_seen", ok, 1);
        check("busy_case_data_bits", frame[7:0], CMD_ENABLE);
        n = 0;
        while (!command_was_sent && n < 2 * IDLE_TO) begin
            n++;
            @(negedge CLOCK_50);
        end
        check("busy_case_done_seen", command_was_sent, 1);
        the_command  = 8'h55;
        send_command = 1'b1;
        @(negedge CLOCK_50);
        send_command = 1'b0;
        repeat (5) @(negedge CLOCK_50);
        check("send_in_done_ignored_busy", busy, 0);
        check("send_in_done_ignored_clk", ps2_clk_drive_low, 0);
        wait_drain("busy_case_drained");

        // Device never clocks: start timeout measured from RTS entry
        send(CMD_ENABLE, 1'b1, OUT_ERR);
        measure_inhibit(n);
        t0 = cyc;
        n = 0;
        while (!error_timed_out && n < 2 * START_TO) begin
            n++;
            @(negedge CLOCK_50);
        end
        check("start_timeout_cycles", cyc - t0, START_TO);
        wait_drain("start_timeout_drained");

        // Reset while bit 4 (a zero) is on the wire
        send(8'h0F, 1'b0, OUT_SENT);
        measure_inhibit(n);
        wait_rts(ok);
        check("reset_case_rts_seen", ok, 1);
        repeat (HALF) @(negedge CLOCK_50);
        for (int i = 0; i < 4; i++) dev_pulse(b);
        dev_clk = 1'b0;
        repeat (HALF / 2) @(negedge CLOCK_50);
        check("bit4_driven_low", ps2_dat_drive_low, 1);
        resetn = 1'b0;
        @(negedge CLOCK_50);
        check("mid_reset_lines", {ps2_clk_drive_low, ps2_dat_drive_low}, 0);
        check("mid_reset_busy", busy, 0);
        check("mid_reset_pulses", {command_was_sent, error_timed_out}, 0);
        dev_clk = 1'b1;
        dev_dat = 1'b1;
        repeat (3) @(negedge CLOCK_50);
        resetn = 1'b1;
        repeat (10) @(negedge CLOCK_50);
        check("no_pulse_after_reset", exp_q.size(), 0);
        run_vec(vecs[0]);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
